// File: rtl/flappy_pkg.sv
// Shared game constants, coordinate width and scanner state encoding.
// Used by flight_physics, pipe_collision_scanner and vga_output.
package flappy_pkg;

  localparam int COORD_W   = 10;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FLOOR_Y   = 480;

  localparam int NUM_PIPES = 4;
  localparam int PIPE_W    = 40;
  localparam int GAP_H     = 120;
  localparam int BIRD_W    = 16;
  localparam int BIRD_H    = 16;

  typedef enum logic [1:0] {
    S_INITIAL = 2'd0,
    S_SCAN    = 2'd1,
    S_DONE    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pipe_overlap_cmp.sv
// Combinational bird-box vs pipe hit test, 11-bit unsigned math.
// Ports: bird_x/bird_y, x_edge/y_edge in; hit out. Edges exclusive.
module pipe_overlap_cmp
  import flappy_pkg::*;
#(
  parameter int PIPE_W = flappy_pkg::PIPE_W,
  parameter int GAP_H  = flappy_pkg::GAP_H,
  parameter int BIRD_W = flappy_pkg::BIRD_W,
  parameter int BIRD_H = flappy_pkg::BIRD_H
) (
  input  logic [COORD_W-1:0] bird_x,
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] x_edge,
  input  logic [COORD_W-1:0] y_edge,
  output logic               hit
);

  localparam int W = COORD_W + 1;

  logic [W-1:0] bx, by, xe, ye;
  logic [W-1:0] bx_r, by_b, xe_r, ye_b;
  logic         x_ov, y_out;

  assign bx   = {1'b0, bird_x};
  assign by   = {1'b0, bird_y};
  assign xe   = {1'b0, x_edge};
  assign ye   = {1'b0, y_edge};
  assign bx_r = bx + W'(BIRD_W);
  assign by_b = by + W'(BIRD_H);
  assign xe_r = xe + W'(PIPE_W);
  assign ye_b = ye + W'(GAP_H);

  assign x_ov  = (bx_r > xe) && (bx < xe_r);
  assign y_out = (by < ye) || (by_b > ye_b);
  assign hit   = x_ov && y_out;

endmodule

// File: rtl/pipe_collision_scanner.sv
// Walks all pipes after Start, reports Lose/Hit_Index, holds Done to Ack.
// Ports: Clk, reset(n), Start, Ack, Bird_X/Y, X/Y_Edge in; Pipe_Index,
// Done, Lose, Hit_Index, q_* out. PIPE_SCAN_EARLY_EXIT_EN: stop on hit.
module pipe_collision_scanner
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES = flappy_pkg::NUM_PIPES,
  parameter int PIPE_W    = flappy_pkg::PIPE_W,
  parameter int GAP_H     = flappy_pkg::GAP_H,
  parameter int BIRD_W    = flappy_pkg::BIRD_W,
  parameter int BIRD_H    = flappy_pkg::BIRD_H,
  parameter int FLOOR_Y   = flappy_pkg::FLOOR_Y,
  localparam int IDX_W =
    (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic [COORD_W-1:0] Bird_X,
  input  logic [COORD_W-1:0] Bird_Y,
  output logic [IDX_W-1:0]   Pipe_Index,
  input  logic [COORD_W-1:0] X_Edge,
  input  logic [COORD_W-1:0] Y_Edge,
  output logic               Done,
  output logic               Lose,
  output logic [IDX_W-1:0]   Hit_Index,
  output logic               q_Initial,
  output logic               q_Scan,
  output logic               q_Done
);

  localparam int CNT_W = $clog2(NUM_PIPES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIPES);
  localparam int W = COORD_W + 1;

  scan_state_e state, state_n;

  logic [COORD_W-1:0] bird_x, bird_y;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   pipe_index, hit_idx;
  logic               lose, hit_seen;
  logic               pipe_hit, cmp_vld;
  logic               scan_end, floor_hit;

  pipe_overlap_cmp #(
    .PIPE_W(PIPE_W),
    .GAP_H (GAP_H),
    .BIRD_W(BIRD_W),
    .BIRD_H(BIRD_H)
  ) u_cmp (
    .bird_x(bird_x),
    .bird_y(bird_y),
    .x_edge(X_Edge),
    .y_edge(Y_Edge),
    .hit   (pipe_hit)
  );

  assign floor_hit =
    ({1'b0, Bird_Y} + W'(BIRD_H)) >= W'(FLOOR_Y);

  // Data on X/Y_Edge lags Pipe_Index by one cycle,
  // so scan cycle k checks pipe k-1.
  assign cmp_vld = (state == S_SCAN) && (cnt != '0);
  assign cnt_nxt = cnt + 1'b1;

`ifdef PIPE_SCAN_EARLY_EXIT_EN
  assign scan_end = (cnt == LAST) || (cmp_vld && pipe_hit);
`else
  assign scan_end = (cnt == LAST);
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= S_INITIAL;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INITIAL: if (Start)    state_n = S_SCAN;
      S_SCAN:    if (scan_end) state_n = S_DONE;
      S_DONE:    if (Ack)      state_n = S_INITIAL;
      default:                 state_n = S_INITIAL;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      bird_x     <= '0;
      bird_y     <= '0;
      cnt        <= '0;
      pipe_index <= '0;
      lose       <= 1'b0;
      hit_idx    <= '0;
      hit_seen   <= 1'b0;
    end else begin
      unique case (state)
        S_INITIAL: begin
          if (Start) begin
            bird_x     <= Bird_X;
            bird_y     <= Bird_Y;
            cnt        <= '0;
            pipe_index <= '0;
            lose       <= floor_hit;
            hit_idx    <= '0;
            hit_seen   <= 1'b0;
          end
        end
        S_SCAN: begin
          cnt <= cnt_nxt;
          if (cnt_nxt < LAST)
            pipe_index <= IDX_W'(cnt_nxt);
          // Only the lowest-index pipe hit is recorded.
          if (cmp_vld && pipe_hit && !hit_seen) begin
            hit_seen <= 1'b1;
            lose     <= 1'b1;
            hit_idx  <= IDX_W'(cnt - 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Pipe_Index = pipe_index;
  assign Lose       = lose;
  assign Hit_Index  = hit_idx;
  assign q_Initial  = (state == S_INITIAL);
  assign q_Scan     = (state == S_SCAN);
  assign q_Done     = (state == S_DONE);
  assign Done       = q_Done;

endmodule

// File: tb/tb_pipe_collision_scanner.sv
// Scoreboard bench for pipe_collision_scanner with a 1-cycle RAM model.
// Expected results are queued at Start and checked on Done rising.
module tb_pipe_collision_scanner;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic [9:0] Bird_X = '0;
  logic [9:0] Bird_Y = '0;
  logic [9:0] X_Edge, Y_Edge;
  logic [1:0] Pipe_Index, Hit_Index;
  logic       Done, Lose;
  logic       q_Initial, q_Scan, q_Done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [9:0] px [4];
  logic [9:0] py [4];

  typedef struct {
    logic       lose;
    logic [1:0] idx;
    int         lat;
  } exp_t;

  exp_t sb [$];

`ifdef PIPE_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  pipe_collision_scanner dut (
    .Clk       (Clk),
    .reset     (reset),
    .Start     (Start),
    .Ack       (Ack),
    .Bird_X    (Bird_X),
    .Bird_Y    (Bird_Y),
    .Pipe_Index(Pipe_Index),
    .X_Edge    (X_Edge),
    .Y_Edge    (Y_Edge),
    .Done      (Done),
    .Lose      (Lose),
    .Hit_Index (Hit_Index),
    .q_Initial (q_Initial),
    .q_Scan    (q_Scan),
    .q_Done    (q_Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc    <= cyc + 1;
    X_Edge <= px[Pipe_Index];
    Y_Edge <= py[Pipe_Index];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (Done && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("lose", Lose, e.lose);
          check("hit_index", Hit_Index, e.idx);
          check("latency", cyc - start_cyc + 1, e.lat);
        end
      end
      done_q = Done;
    end
  end

  task automatic load(input logic [9:0] bx, by,
                      input logic [39:0] xs, ys);
    for (int i = 0; i < 4; i++) begin
      px[i] = xs[i*10 +: 10];
      py[i] = ys[i*10 +: 10];
    end
    Bird_X = bx;
    Bird_Y = by;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!Done && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!Done) check("done_timeout", 0, 1);
  endtask

  task automatic do_ack(input logic el, input logic [1:0] ei);
    @(negedge Clk);
    Ack = 1'b1;
    @(posedge Clk); #1;
    check("ack_q_initial", q_Initial, 1);
    check("ack_done_low", Done, 0);
    check("held_lose", Lose, el);
    check("held_idx", Hit_Index, ei);
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  task automatic run_scan(input logic [9:0] bx, by,
                          input logic [39:0] xs, ys,
                          input logic el,
                          input logic [1:0] ei,
                          input int lat_full,
                          input int lat_early,
                          input logic midy);
    exp_t e;
    @(negedge Clk);
    load(bx, by, xs, ys);
    e.lose = el;
    e.idx  = ei;
    e.lat  = EARLY ? lat_early : lat_full;
    sb.push_back(e);
    Start = 1'b1;
    @(posedge Clk); #1;
    start_cyc = cyc;
    check("q_scan", q_Scan, 1);
    @(negedge Clk);
    Start = 1'b0;
    if (midy) begin
      @(negedge Clk);
      Bird_Y = 10'd300;
    end
    wait_done();
    do_ack(el, ei);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      px[i] = 10'd900;
      py[i] = 10'd150;
    end
    repeat (2) @(posedge Clk);
    #1;
    check("rst_q_initial", q_Initial, 1);
    check("rst_done", Done, 0);
    check("rst_lose", Lose, 0);
    check("rst_hit", Hit_Index, 0);
    check("rst_pidx", Pipe_Index, 0);
    @(negedge Clk);
    reset = 1'b1;

    // clear pass
    run_scan(10'd100, 10'd200,
             {10'd900, 10'd700, 10'd500, 10'd300},
             {10'd150, 10'd150, 10'd150, 10'd150},
             1'b0, 2'd0, 6, 6, 1'b0);
    // bird above gap on pipe 2
    run_scan(10'd100, 10'd100,
             {10'd900, 10'd110, 10'd500, 10'd300},
             {10'd150, 10'd150, 10'd150, 10'd150},
             1'b1, 2'd2, 6, 5, 1'b0);
    // touching edges on every side
    run_scan(10'd100, 10'd150,
             {10'd900, 10'd60, 10'd116, 10'd100},
             {10'd150, 10'd300, 10'd150, 10'd46},
             1'b0, 2'd0, 6, 6, 1'b0);
    // floor only
    run_scan(10'd100, 10'd470,
             {10'd900, 10'd700, 10'd500, 10'd300},
             {10'd150, 10'd150, 10'd150, 10'd150},
             1'b1, 2'd0, 6, 6, 1'b0);
    // pipes 1 and 3 hit, Bird_Y moved mid-scan
    run_scan(10'd100, 10'd100,
             {10'd90, 10'd800, 10'd100, 10'd600},
             {10'd250, 10'd150, 10'd250, 10'd150},
             1'b1, 2'd1, 6, 4, 1'b1);
    // below gap on pipe 0
    run_scan(10'd200, 10'd300,
             {10'd900, 10'd700, 10'd500, 10'd190},
             {10'd150, 10'd150, 10'd150, 10'd100},
             1'b1, 2'd0, 6, 3, 1'b0);

    // reset during scan cycle 3 aborts
    @(negedge Clk);
    load(10'd100, 10'd470,
         {10'd900, 10'd700, 10'd500, 10'd300},
         {10'd150, 10'd150, 10'd150, 10'd150});
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check("pre_rst_lose", Lose, 1);
    check("pre_rst_pidx", Pipe_Index, 3);
    reset = 1'b0;
    #1;
    check("arst_q_initial", q_Initial, 1);
    check("arst_q_scan", q_Scan, 0);
    check("arst_done", Done, 0);
    check("arst_lose", Lose, 0);
    check("arst_hit", Hit_Index, 0);
    check("arst_pidx", Pipe_Index, 0);
    @(negedge Clk);
    reset = 1'b1;
    run_scan(10'd100, 10'd470,
             {10'd900, 10'd700, 10'd500, 10'd300},
             {10'd150, 10'd150, 10'd150, 10'd150},
             1'b1, 2'd0, 6, 6, 1'b0);

    // Start held in DONE, then Start with Ack
    @(negedge Clk);
    load(10'd100, 10'd100,
         {10'd900, 10'd110, 10'd500, 10'd300},
         {10'd150, 10'd150, 10'd150, 10'd150});
    e.lose = 1'b1;
    e.idx  = 2'd2;
    e.lat  = EARLY ? 5 : 6;
    sb.push_back(e);
    Start = 1'b1;
    @(posedge Clk); #1;
    start_cyc = cyc;
    wait_done();
    repeat (3) begin
      @(posedge Clk); #1;
      check("stay_done", q_Done, 1);
    end
    @(negedge Clk);
    load(10'd100, 10'd200,
         {10'd900, 10'd700, 10'd500, 10'd300},
         {10'd150, 10'd150, 10'd150, 10'd150});
    Ack = 1'b1;
    @(posedge Clk); #1;
    check("ack_wins", q_Initial, 1);
    @(negedge Clk);
    Ack = 1'b0;
    e.lose = 1'b0;
    e.idx  = 2'd0;
    e.lat  = 6;
    sb.push_back(e);
    @(posedge Clk); #1;
    start_cyc = cyc;
    check("start_after_ack", q_Scan, 1);
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    do_ack(1'b0, 2'd0);

    repeat (4) @(posedge Clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_collision_scanner.md
Name: pipe_collision_scanner

Overview:
- Reader-side counterpart of the pipe-position RAM: on Start, walks pipe indices 0..NUM_PIPES-1, fetches each pipe's X edge (RAM) and gap-top Y edge (ROM), and tests overlap against the latched bird box.
- Reports Lose/Hit_Index and holds Done until Ack; sits between flight_physics (bird coords) and the RAM/ROM pair, clocked by sys_clk.

Parameters:
- NUM_PIPES, 4, pipes scanned per check (index width = 2 at default)
- PIPE_W, 40, pipe width in px
- GAP_H, 120, vertical gap height in px
- BIRD_W, 16, bird box width in px
- BIRD_H, 16, bird box height in px
- FLOOR_Y, 480, floor line; bird bottom reaching it loses

Ports:
- Clk  in  1  system clock (sys_clk)
- reset  in  1  asynchronous, active-low reset
- Start  in  1  request a collision scan; sampled in INITIAL only
- Ack  in  1  acknowledge result; sampled in DONE only
- Bird_X  in  10  bird left edge, px
- Bird_Y  in  10  bird top edge, px
- Pipe_Index  out  2  read address to X RAM / Y ROM
- X_Edge  in  10  pipe left edge at Pipe_Index, valid 1 cycle after address
- Y_Edge  in  10  gap top at Pipe_Index, valid 1 cycle after address
- Done  out  1  result valid (high in DONE)
- Lose  out  1  collision or floor hit
- Hit_Index  out  2  lowest-index pipe hit; 0 if none
- q_Initial, q_Scan, q_Done  out  1 each  one-hot state

Behaviour:
- Reset (reset=0, async): state INITIAL; Pipe_Index=0, Done=0, Lose=0, Hit_Index=0, q_Initial=1. Reset mid-scan aborts; no partial result kept.
- INITIAL: on Start=1, latch Bird_X/Bird_Y into internal regs, set Pipe_Index=0, clear Lose/Hit_Index, compute floor hit (Bird_Y+BIRD_H >= FLOOR_Y) into Lose; go SCAN. Start=0: stay.
- SCAN (pipelined, 1-cycle read latency): cycle k drives Pipe_Index=k (k<NUM_PIPES) and compares data returned for index k-1 (k>=1). Lasts NUM_PIPES+1 cycles; Pipe_Index holds last value on the final compare cycle.
- Hit test for pipe i, all arithmetic 11-bit unsigned (no wrap): x_ov = (Bird_X+BIRD_W > X_Edge) && (Bird_X < X_Edge+PIPE_W); y_out = (Bird_Y < Y_Edge) || (Bird_Y+BIRD_H > Y_Edge+GAP_H); hit = x_ov && y_out. Boundaries exclusive: touching edges are not hits.
- First hit sets Lose=1 and Hit_Index=i; later hits never overwrite Hit_Index. Floor hit alone: Lose=1, Hit_Index=0.
- After last compare: go DONE. Done=1, outputs stable.
- DONE: Ack=1 -> INITIAL next cycle, Done=0; Lose/Hit_Index held until next Start. Start in DONE ignored; Start and Ack both high in DONE: Ack wins, Start not seen until next INITIAL cycle.
- Bird_X/Bird_Y changes during SCAN have no effect (latched copy used).
- Latency Start-sample to Done=1: NUM_PIPES+2 cycles (6 at default).

Optional Feature:
- Macro PIPE_SCAN_EARLY_EXIT_EN.
- Defined: first pipe hit ends SCAN immediately; DONE entered on the cycle after the hitting compare (hit on pipe 0 -> Done 3 cycles after Start-sample). Floor hit does not skip the scan.
- Undefined: always full NUM_PIPES+1 scan cycles. Lose/Hit_Index identical in both builds; only latency differs.

Decomposition:
- Package flappy_pkg: COORD_W=10, screen constants (640x480, FLOOR_Y), bird/pipe/gap default dimensions, state encoding for INITIAL/SCAN/DONE; shared with flight_physics and vga_output.
- One sub-module pipe_overlap_cmp: purely combinational hit test (bird box, X_Edge, Y_Edge -> hit); reused by vga_output debug overlay.

Test Plan:
- Bird (100,200), pipes X={300,500,700,900}, Y=150 all; Start -> Done at cycle 6, Lose=0, Hit_Index=0; Ack -> q_Initial next cycle.
- Bird (100,100), pipe2 X=110 Y=150 (bird above gap), others far -> Lose=1, Hit_Index=2; early-exit build: Done at cycle 5.
- Bird (100,150), pipe1 X=116 Y=150: touches left edge exactly and gap top exactly -> Lose=0.
- Bird (100,470), no pipe overlap -> Lose=1 (floor), Hit_Index=0, full-length scan in both builds.
- Pipes 1 and 3 both hit -> Hit_Index=1; Bird_Y changed to 300 mid-scan -> result unchanged.
- reset low during SCAN cycle 3 -> all outputs at reset values immediately; subsequent Start rescans correctly; Start held in DONE without Ack -> stays DONE.
